// File: rtl/mc_ctrl_pkg.sv
// Shared types for the handshaked multicycle MIPS control unit: states, opcodes,
// datapath select encodings, trap causes and the decoded instruction class.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDI_EX = 4'd10,
        ST_ADDI_WB = 4'd11,
        ST_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // CLS_NONE doubles as "illegal opcode" so the reset value of the latch is harmless.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4,
        CLS_BNE  = 3'd5,
        CLS_ADDI = 3'd6,
        CLS_J    = 3'd7
    } cls_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    function automatic cls_t decode_op(input logic [5:0] op, input logic bne_en);
        cls_t c;
        case (op)
            OP_R:    c = CLS_R;
            OP_LW:   c = CLS_LW;
            OP_SW:   c = CLS_SW;
            OP_BEQ:  c = CLS_BEQ;
            OP_BNE:  c = bne_en ? CLS_BNE : CLS_NONE;
            OP_ADDI: c = CLS_ADDI;
            OP_J:    c = CLS_J;
            default: c = CLS_NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; expire_o is combinational and
// fires on the MEM_TIMEOUT-th not-ready cycle unless mem_ready arrives that same cycle.
module mc_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic count_en_i,
    input  logic mem_ready_i,
    output logic expire_o
);
    import mc_ctrl_pkg::*;

    localparam logic [TW-1:0] LIMIT   = TW'(MEM_TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX = '1;

    logic [TW-1:0] cnt_q, cnt_d;

    // Saturating so a disabled timeout (MEM_TIMEOUT=0) cannot wrap during a long stall.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || mem_ready_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (MEM_TIMEOUT != 0) && count_en_i && !clear_i && !mem_ready_i
                      && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with memory ready handshake, bounded memory wait and a sticky trap.
// Outputs are Moore-decoded except IRWrite/PCWrite in FETCH, which follow mem_ready.
module mc_ctrl_hs #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ENABLE_BNE  = 1,
    parameter int TW          = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic [1:0] pc_source_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] alu_src_b_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o,
    output logic [3:0] state_dbg_o
);
    import mc_ctrl_pkg::*;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    logic       trap_req;
    logic [1:0] cause_req;
    logic       in_mem;
    logic       expire;
    ctrl_t      ctrl, ctrl_out;

    assign in_mem = is_mem_state(state_q);

    // Counter is held at zero outside memory states, so it is already clear on entry.
    mc_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TW          (TW)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (!in_mem),
        .count_en_i  (in_mem),
        .mem_ready_i (mem_ready_i),
        .expire_o    (expire)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        ctrl      = '0;
        trap_req  = 1'b0;
        cause_req = CAUSE_NONE;

        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (expire) begin
                    trap_req  = 1'b1;
                    cause_req = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                cls_d = decode_op(opcode_i, ENABLE_BNE != 0);
                case (cls_d)
                    CLS_LW, CLS_SW:   state_d = ST_MEMADR;
                    CLS_R:            state_d = ST_EXEC;
                    CLS_BEQ, CLS_BNE: state_d = ST_BRANCH;
                    CLS_ADDI:         state_d = ST_ADDI_EX;
                    CLS_J:            state_d = ST_JUMP;
                    default: begin
                        trap_req  = 1'b1;
                        cause_req = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d = (cls_q == CLS_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_MEMWB;
                end else if (expire) begin
                    trap_req  = 1'b1;
                    cause_req = CAUSE_TIMEOUT;
                end
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d = ST_FETCH;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_FETCH;
                end else if (expire) begin
                    trap_req  = 1'b1;
                    cause_req = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d = ST_RWB;
            end
            ST_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (cls_q == CLS_BNE);
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d = ST_FETCH;
            end
            ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                trap_req  = 1'b1;
                cause_req = CAUSE_ILLEGAL;
            end
        endcase

        if (trap_req) begin
            state_d = ST_TRAP;
        end
    end

    // First trap cause sticks; nothing but reset can clear or overwrite it.
    always_comb begin
        trap_d  = trap_q | trap_req;
        cause_d = cause_q;
        if (trap_req && (cause_q == CAUSE_NONE)) begin
            cause_d = cause_req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NONE;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign ctrl_out = rst_n_i ? ctrl : '0;

    assign pc_write_o      = ctrl_out.pc_write;
    assign pc_write_cond_o = ctrl_out.pc_write_cond;
    assign branch_ne_o     = ctrl_out.branch_ne;
    assign i_or_d_o        = ctrl_out.i_or_d;
    assign mem_read_o      = ctrl_out.mem_read;
    assign mem_write_o     = ctrl_out.mem_write;
    assign ir_write_o      = ctrl_out.ir_write;
    assign mem_to_reg_o    = ctrl_out.mem_to_reg;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign reg_write_o     = ctrl_out.reg_write;
    assign reg_dst_o       = ctrl_out.reg_dst;
    assign pc_source_o     = ctrl_out.pc_source;
    assign alu_op_o        = ctrl_out.alu_op;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign trap_o          = trap_q;
    assign trap_cause_o    = cause_q;
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench: one default instance and one with bne disabled share all stimulus.
module tb_mc_ctrl_hs;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, reg_dst, trap;
    logic [1:0] pc_source, alu_op, alu_src_b, trap_cause;
    logic [3:0] state_dbg;

    logic       pc_write_nb, pc_write_cond_nb, branch_ne_nb, i_or_d_nb, mem_read_nb, mem_write_nb;
    logic       ir_write_nb, mem_to_reg_nb, alu_src_a_nb, reg_write_nb, reg_dst_nb, trap_nb;
    logic [1:0] pc_source_nb, alu_op_nb, alu_src_b_nb, trap_cause_nb;
    logic [3:0] state_dbg_nb;

    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, alu_src_a, reg_write, reg_dst, pc_source, alu_op, alu_src_b};

    int checks = 0;
    int errors = 0;
    int ncyc, ir_cnt, rw_cnt, mw_cnt;

    mc_ctrl_hs dut (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
        .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
        .reg_write_o(reg_write), .reg_dst_o(reg_dst), .pc_source_o(pc_source),
        .alu_op_o(alu_op), .alu_src_b_o(alu_src_b), .trap_o(trap),
        .trap_cause_o(trap_cause), .state_dbg_o(state_dbg)
    );

    mc_ctrl_hs #(.MEM_TIMEOUT(15), .ENABLE_BNE(0), .TW(4)) dut_nb (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write_nb), .pc_write_cond_o(pc_write_cond_nb), .branch_ne_o(branch_ne_nb),
        .i_or_d_o(i_or_d_nb), .mem_read_o(mem_read_nb), .mem_write_o(mem_write_nb),
        .ir_write_o(ir_write_nb), .mem_to_reg_o(mem_to_reg_nb), .alu_src_a_o(alu_src_a_nb),
        .reg_write_o(reg_write_nb), .reg_dst_o(reg_dst_nb), .pc_source_o(pc_source_nb),
        .alu_op_o(alu_op_nb), .alu_src_b_o(alu_src_b_nb), .trap_o(trap_nb),
        .trap_cause_o(trap_cause_nb), .state_dbg_o(state_dbg_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply mem_ready for the current cycle, let outputs settle, check the state.
    task automatic cyc(input logic rdy, input logic [3:0] st, input string tag);
        mem_ready = rdy;
        #1;
        chk(tag, {28'd0, state_dbg}, {28'd0, st});
        ncyc++;
        ir_cnt += int'(ir_write);
        rw_cnt += int'(reg_write);
        mw_cnt += int'(mem_write);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 6'b000000;
        mem_ready = 1'b0;
        ncyc = 0; ir_cnt = 0; rw_cnt = 0; mw_cnt = 0;
        repeat (2) tick();
        #1;
        chk("rst_state", {28'd0, state_dbg}, 32'd0);
        chk("rst_memread_forced", {31'd0, mem_read}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_cause", {30'd0, trap_cause}, 32'd0);
        rst_n = 1'b1;

        // R-type, zero wait
        opcode = 6'b000000;
        cyc(1'b1, 4'd0, "r_fetch");
        chk("r_fetch_irw", {31'd0, ir_write}, 32'd1);
        chk("r_fetch_pcw", {31'd0, pc_write}, 32'd1);
        chk("r_fetch_srcb", {30'd0, alu_src_b}, 32'd1);
        tick();
        cyc(1'b1, 4'd1, "r_decode");
        chk("r_decode_srcb", {30'd0, alu_src_b}, 32'd3);
        tick();
        cyc(1'b1, 4'd6, "r_exec");
        chk("r_exec_aluop", {30'd0, alu_op}, 32'd2);
        tick();
        cyc(1'b1, 4'd7, "r_rwb");
        chk("r_rwb_regw", {31'd0, reg_write}, 32'd1);
        chk("r_rwb_regdst", {31'd0, reg_dst}, 32'd1);
        tick();

        // lw with 3 fetch waits and 2 read waits
        opcode = 6'b100011;
        ncyc = 0; ir_cnt = 0; rw_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd0, "lw_fetch_wait");
            chk("lw_fetch_wait_irw", {31'd0, ir_write}, 32'd0);
            tick();
        end
        cyc(1'b1, 4'd0, "lw_fetch");
        tick();
        cyc(1'b0, 4'd1, "lw_decode");
        tick();
        cyc(1'b0, 4'd2, "lw_memadr");
        chk("lw_memadr_srcb", {30'd0, alu_src_b}, 32'd2);
        tick();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 4'd3, "lw_memrd_wait");
            chk("lw_memrd_iord", {31'd0, i_or_d}, 32'd1);
            tick();
        end
        cyc(1'b1, 4'd3, "lw_memrd");
        tick();
        cyc(1'b1, 4'd4, "lw_memwb");
        chk("lw_memwb_m2r", {31'd0, mem_to_reg}, 32'd1);
        tick();
        chk("lw_cycles", ncyc, 32'd10);
        chk("lw_irw_pulses", ir_cnt, 32'd1);
        chk("lw_regw_pulses", rw_cnt, 32'd1);

        // bne: branch on default instance, illegal on the bne-disabled one
        opcode = 6'b000101;
        cyc(1'b1, 4'd0, "bne_fetch");
        tick();
        cyc(1'b1, 4'd1, "bne_decode");
        tick();
        cyc(1'b1, 4'd8, "bne_branch");
        chk("bne_pcwc", {31'd0, pc_write_cond}, 32'd1);
        chk("bne_branchne", {31'd0, branch_ne}, 32'd1);
        chk("bne_aluop", {30'd0, alu_op}, 32'd1);
        chk("bne_pcsrc", {30'd0, pc_source}, 32'd1);
        chk("nb_state", {28'd0, state_dbg_nb}, 32'd12);
        chk("nb_trap", {31'd0, trap_nb}, 32'd1);
        chk("nb_cause", {30'd0, trap_cause_nb}, 32'd1);
        tick();

        // beq
        opcode = 6'b000100;
        cyc(1'b1, 4'd0, "beq_fetch");
        tick();
        cyc(1'b1, 4'd1, "beq_decode");
        tick();
        cyc(1'b1, 4'd8, "beq_branch");
        chk("beq_branchne", {31'd0, branch_ne}, 32'd0);
        chk("beq_pcwc", {31'd0, pc_write_cond}, 32'd1);
        chk("nb_trap_held", {28'd0, state_dbg_nb}, 32'd12);
        chk("nb_cause_held", {30'd0, trap_cause_nb}, 32'd1);
        tick();

        // j
        opcode = 6'b000010;
        cyc(1'b1, 4'd0, "j_fetch");
        tick();
        cyc(1'b1, 4'd1, "j_decode");
        tick();
        cyc(1'b1, 4'd9, "j_jump");
        chk("j_pcw", {31'd0, pc_write}, 32'd1);
        chk("j_pcsrc", {30'd0, pc_source}, 32'd2);
        tick();

        // addi
        opcode = 6'b001000;
        cyc(1'b1, 4'd0, "addi_fetch");
        tick();
        cyc(1'b1, 4'd1, "addi_decode");
        tick();
        cyc(1'b1, 4'd10, "addi_ex");
        chk("addi_ex_srca", {31'd0, alu_src_a}, 32'd1);
        chk("addi_ex_srcb", {30'd0, alu_src_b}, 32'd2);
        tick();
        cyc(1'b1, 4'd11, "addi_wb");
        chk("addi_wb_regw", {31'd0, reg_write}, 32'd1);
        chk("addi_wb_regdst", {31'd0, reg_dst}, 32'd0);
        tick();

        // illegal opcode, then 20 further trap cycles
        opcode = 6'b111111;
        cyc(1'b1, 4'd0, "ill_fetch");
        tick();
        cyc(1'b1, 4'd1, "ill_decode");
        tick();
        for (int i = 0; i < 21; i++) begin
            cyc(1'b1, 4'd12, "ill_trap_state");
            chk("ill_trap_outs", {15'd0, outs}, 32'd0);
            tick();
        end
        chk("ill_trap", {31'd0, trap}, 32'd1);
        chk("ill_cause", {30'd0, trap_cause}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ill_rst_outs", {15'd0, outs}, 32'd0);
        tick();
        #1;
        chk("ill_rst_state", {28'd0, state_dbg}, 32'd0);
        chk("ill_rst_trap", {31'd0, trap}, 32'd0);
        chk("ill_rst_cause", {30'd0, trap_cause}, 32'd0);
        chk("nb_rst_trap", {31'd0, trap_nb}, 32'd0);
        rst_n = 1'b1;

        // sw with memory never ready: 15 write cycles, then timeout trap
        opcode = 6'b101011;
        cyc(1'b1, 4'd0, "swto_fetch");
        tick();
        cyc(1'b1, 4'd1, "swto_decode");
        tick();
        cyc(1'b1, 4'd2, "swto_memadr");
        tick();
        mw_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 4'd5, "swto_memwr");
            tick();
        end
        cyc(1'b0, 4'd12, "swto_trap_state");
        chk("swto_memwrite_cycles", mw_cnt, 32'd15);
        chk("swto_memwrite_drop", {31'd0, mem_write}, 32'd0);
        chk("swto_trap", {31'd0, trap}, 32'd1);
        chk("swto_cause", {30'd0, trap_cause}, 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // sw with ready arriving exactly on the 15th cycle: completes normally
        cyc(1'b1, 4'd0, "swok_fetch");
        tick();
        cyc(1'b1, 4'd1, "swok_decode");
        tick();
        cyc(1'b1, 4'd2, "swok_memadr");
        tick();
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 4'd5, "swok_memwr_wait");
            tick();
        end
        cyc(1'b1, 4'd5, "swok_memwr_last");
        chk("swok_memwrite", {31'd0, mem_write}, 32'd1);
        tick();
        cyc(1'b1, 4'd0, "swok_back_fetch");
        chk("swok_trap", {31'd0, trap}, 32'd0);

        // reset during a MEMRD wait
        opcode = 6'b100011;
        tick();
        cyc(1'b1, 4'd1, "rstrd_decode");
        tick();
        cyc(1'b1, 4'd2, "rstrd_memadr");
        tick();
        cyc(1'b0, 4'd3, "rstrd_memrd0");
        tick();
        cyc(1'b0, 4'd3, "rstrd_memrd1");
        chk("rstrd_cnt_mid", {28'd0, dut.u_timer.cnt_q}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstrd_memread_forced", {31'd0, mem_read}, 32'd0);
        tick();
        #1;
        chk("rstrd_state", {28'd0, state_dbg}, 32'd0);
        chk("rstrd_cnt", {28'd0, dut.u_timer.cnt_q}, 32'd0);
        chk("rstrd_memread", {31'd0, mem_read}, 32'd0);
        chk("rstrd_trap", {31'd0, trap}, 32'd0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
